// File: rtl/blowfish_pkg.sv
// Shared types and helpers for the pipelined Blowfish F-function and its S-box RAMs.
package blowfish_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int SBOX_COUNT = 4;

  // Post-reset S-box fill patterns.
  localparam int SBOX_INIT_ZERO  = 0;
  localparam int SBOX_INIT_INDEX = 1;

  // Widest word the lane helper handles; WORD_W must not exceed this.
  localparam int LANE_MAX_W = 64;

  // Lane 0 is the least significant byte field of the word.
  function automatic logic [LANE_MAX_W-1:0] byte_lane(
    input logic [LANE_MAX_W-1:0] word,
    input int                    lane,
    input int                    byte_w
  );
    logic [LANE_MAX_W-1:0] mask;
    mask = (LANE_MAX_W'(1) << byte_w) - LANE_MAX_W'(1);
    return (word >> (lane * byte_w)) & mask;
  endfunction

endpackage

// File: rtl/blowfish_sbox_ram.sv
// Single S-box: one write port and one enabled synchronous read port, read-before-write.
module blowfish_sbox_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  assign rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;
  assign rd_data   = rd_data_q;

  // NOTE: the array has no reset so it maps onto block RAM; the init FSM fills it instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // NOTE: non-blocking here is what makes a same-edge read see the old entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data_q <= '0;
    else      rd_data_q <= rd_data_d;
  end

endmodule

// File: rtl/blowfish_f_pipe.sv
// Three-stage Blowfish F(x) = ((S0[a]+S1[b]) ^ S2[c]) + S3[d] with loadable S-boxes and valid/ready flow.
module blowfish_f_pipe
  import blowfish_pkg::*;
#(
  parameter  int WORD_W    = 32,
  parameter  int SBOX_INIT = 0,
  localparam int BYTE_W    = WORD_W / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  input  logic              sbox_wr_en,
  input  logic [1:0]        sbox_wr_sel,
  input  logic [BYTE_W-1:0] sbox_wr_addr,
  input  logic [WORD_W-1:0] sbox_wr_data,
  output logic              init_done
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;

  logic              v1_q, v1_d;
  logic [WORD_W-1:0] t_q, t_d;
  logic [WORD_W-1:0] s3_q, s3_d;
  logic              v2_q, v2_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic              advance;
  logic              accept;
  logic              in_init;
  logic              running;

  logic [SBOX_COUNT-1:0] wr_en;
  logic [BYTE_W-1:0]     wr_addr;
  logic [WORD_W-1:0]     wr_data;
  logic [BYTE_W-1:0]     rd_addr [SBOX_COUNT];
  logic [WORD_W-1:0]     s_rd    [SBOX_COUNT];

  assign in_init  = (state_q == ST_INIT);
  assign running  = (state_q == ST_RUN);
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = running && advance;
  assign accept   = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    unique case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + BYTE_W'(1);
        if (init_cnt_q == {BYTE_W{1'b1}}) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // During INIT all four boxes take the fill value; in RUN only the selected box is written.
  always_comb begin
    wr_en   = '0;
    wr_addr = sbox_wr_addr;
    wr_data = sbox_wr_data;
    if (in_init) begin
      wr_addr = init_cnt_q;
      wr_data = (SBOX_INIT == SBOX_INIT_INDEX) ? WORD_W'(init_cnt_q) : '0;
    end
    for (int i = 0; i < SBOX_COUNT; i++) begin
      wr_en[i] = in_init || (running && sbox_wr_en && (sbox_wr_sel == 2'(i)));
    end
  end

  // Box 0 is indexed by the most significant byte field.
  always_comb begin
    for (int i = 0; i < SBOX_COUNT; i++) begin
      rd_addr[i] = BYTE_W'(byte_lane(LANE_MAX_W'(in_data), SBOX_COUNT - 1 - i, BYTE_W));
    end
  end

  for (genvar g = 0; g < SBOX_COUNT; g++) begin : g_sbox
    blowfish_sbox_ram #(
      .ADDR_W (BYTE_W),
      .DATA_W (WORD_W)
    ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[g]),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (advance),
      .rd_addr (rd_addr[g]),
      .rd_data (s_rd[g])
    );
  end

  // All stages move together; a stall freezes the whole pipe, bubbles included.
  always_comb begin
    v1_d        = v1_q;
    t_d         = t_q;
    s3_d        = s3_q;
    v2_d        = v2_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (advance) begin
      v1_d        = accept;
      t_d         = (s_rd[0] + s_rd[1]) ^ s_rd[2];
      s3_d        = s_rd[3];
      v2_d        = v1_q;
      out_data_d  = t_q + s3_q;
      out_valid_d = v2_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      v1_q        <= 1'b0;
      t_q         <= '0;
      s3_q        <= '0;
      v2_q        <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      v1_q        <= v1_d;
      t_q         <= t_d;
      s3_q        <= s3_d;
      v2_q        <= v2_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_blowfish_f_pipe.sv
// Self-checking bench for blowfish_f_pipe: directed vectors plus a random stream against an S-box model.
module tb_blowfish_f_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        in_valid, in_ready, out_valid, out_ready, init_done;
  logic [31:0] in_data, out_data, sbox_wr_data;
  logic        sbox_wr_en;
  logic [1:0]  sbox_wr_sel;
  logic [7:0]  sbox_wr_addr;

  logic        b_in_valid, b_in_ready, b_out_valid, b_init_done;
  logic [31:0] b_in_data, b_out_data;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;

  logic [31:0] sb [4][256];
  logic [31:0] exp_q [$];
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data;

  typedef struct {
    string       name;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  blowfish_f_pipe #(.WORD_W(32), .SBOX_INIT(0)) u0 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .sbox_wr_en   (sbox_wr_en),
    .sbox_wr_sel  (sbox_wr_sel),
    .sbox_wr_addr (sbox_wr_addr),
    .sbox_wr_data (sbox_wr_data),
    .init_done    (init_done)
  );

  blowfish_f_pipe #(.WORD_W(32), .SBOX_INIT(1)) u1 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (b_in_valid),
    .in_ready     (b_in_ready),
    .in_data      (b_in_data),
    .out_valid    (b_out_valid),
    .out_ready    (1'b1),
    .out_data     (b_out_data),
    .sbox_wr_en   (1'b0),
    .sbox_wr_sel  (2'd0),
    .sbox_wr_addr (8'd0),
    .sbox_wr_data (32'd0),
    .init_done    (b_init_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] f_model(input logic [31:0] x);
    return ((sb[0][x[31:24]] + sb[1][x[23:16]]) ^ sb[2][x[15:8]]) + sb[3][x[7:0]];
  endfunction

  // Scoreboard: predictions use the S-box image before any same-cycle write.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      hold_pend = 1'b0;
      for (int b = 0; b < 4; b++)
        for (int a = 0; a < 256; a++) sb[b][a] = '0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, hold_data);
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (out_valid && out_ready) begin
        check("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("scoreboard", out_data, exp_q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) exp_q.push_back(f_model(in_data));
      if (sbox_wr_en && init_done) sb[sbox_wr_sel][sbox_wr_addr] = sbox_wr_data;
    end
  end

  task automatic send(input logic [31:0] w);
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [31:0] exp, output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check(name, out_data, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic sbox_write(input logic [1:0] sel, input logic [7:0] addr, input logic [31:0] data);
    sbox_wr_en   = 1'b1;
    sbox_wr_sel  = sel;
    sbox_wr_addr = addr;
    sbox_wr_data = data;
    @(posedge clk);
    #1;
    sbox_wr_en = 1'b0;
  endtask

  // Called just after reset release at a falling edge; counts rising edges until init_done.
  task automatic wait_init(input string name, input int wr_cycles);
    int   n;
    logic saw_ready, saw_valid;
    n         = 0;
    saw_ready = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (n >= wr_cycles) sbox_wr_en = 1'b0;
      if (init_done) break;
      saw_ready |= in_ready;
      saw_valid |= out_valid;
    end
    check({name, "_cycles"}, 32'(n), 32'd256);
    check({name, "_in_ready_low"}, 32'(saw_ready), 32'd0);
    check({name, "_no_out_valid"}, 32'(saw_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int n0;

    vecs[0] = '{"v_01020304", 32'h01020304, 32'h0000001C};
    vecs[1] = '{"v_wrap",     32'hFFFFFFFF, 32'h00000005};
    vecs[2] = '{"v_deadbeef", 32'hDEADBEEF, 32'h00000000};
    vecs[3] = '{"v_zero",     32'h00000000, 32'h00000000};
    vecs[4] = '{"v_01ff0304", 32'h01FF0304, 32'h0000001D};
    vecs[5] = '{"v_ff020304", 32'hFF020304, 32'h0000001E};

    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b1;
    sbox_wr_en   = 1'b0;
    sbox_wr_sel  = '0;
    sbox_wr_addr = '0;
    sbox_wr_data = '0;
    b_in_valid   = 1'b0;
    b_in_data    = '0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    rst = 1'b1;
    wait_init("init0", 0);
    check("u1_init_done", 32'(b_init_done), 32'd1);

    // Index-fill boxes: ((1+2)^3)+4
    b_in_data  = 32'h01020304;
    b_in_valid = 1'b1;
    check("u1_in_ready", 32'(b_in_ready), 32'd1);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_out_valid) break;
    end
    check("u1_out_valid", 32'(b_out_valid), 32'd1);
    check("u1_f_index", b_out_data, 32'h00000004);
    @(posedge clk);
    #1;

    // Zero-filled boxes, three-cycle latency
    send(32'hDEADBEEF);
    wait_out("zero_fill", 32'h0, lat);
    check("latency", 32'(lat), 32'd3);

    sbox_write(2'd0, 8'h01, 32'h00000001);
    sbox_write(2'd1, 8'h02, 32'h00000002);
    sbox_write(2'd2, 8'h03, 32'h0000000F);
    sbox_write(2'd3, 8'h04, 32'h00000010);
    sbox_write(2'd0, 8'hFF, 32'hFFFFFFFF);
    sbox_write(2'd1, 8'hFF, 32'h00000001);
    sbox_write(2'd2, 8'hFF, 32'h00000000);
    sbox_write(2'd3, 8'hFF, 32'h00000005);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].x);
      wait_out(vecs[i].name, vecs[i].y, lat);
    end

    // Read-before-write: write S0[1] on the same edge the input is accepted
    check("rbw_in_ready", 32'(in_ready), 32'd1);
    in_data      = 32'h01020304;
    in_valid     = 1'b1;
    sbox_wr_en   = 1'b1;
    sbox_wr_sel  = 2'd0;
    sbox_wr_addr = 8'h01;
    sbox_wr_data = 32'h00000100;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    sbox_wr_en = 1'b0;
    send(32'h01020304);
    wait_out("rbw_old", 32'h0000001C, lat);
    wait_out("rbw_new", 32'h0000011D, lat);

    // Backpressure: five words, out_ready low from the third cycle
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 5; i++) send($urandom & 32'h07070707);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        repeat (4) begin
          @(negedge clk);
          check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (n_out - n0 >= 5) break;
    end
    check("bp_count", 32'(n_out - n0), 32'd5);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Random traffic with concurrent S-box writes on a narrow address range
    repeat (400) begin
      in_valid     = ($urandom % 2) == 0;
      in_data      = $urandom & 32'h07070707;
      out_ready    = ($urandom % 4) != 0;
      sbox_wr_en   = ($urandom % 4) == 0;
      sbox_wr_sel  = 2'($urandom % 4);
      sbox_wr_addr = 8'($urandom % 8);
      sbox_wr_data = $urandom;
      @(posedge clk);
      #1;
    end
    in_valid   = 1'b0;
    sbox_wr_en = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("rand_drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Reset with words in flight, then a write attempt during the repeated INIT
    out_ready = 1'b0;
    send(32'h00010203);
    send(32'h04050607);
    send(32'h01020304);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    out_ready    = 1'b1;
    sbox_wr_en   = 1'b1;
    sbox_wr_sel  = 2'd0;
    sbox_wr_addr = 8'h01;
    sbox_wr_data = 32'h00000ABC;
    rst = 1'b1;
    wait_init("init1", 10);
    send(32'h01020304);
    wait_out("wr_ignored_in_init", 32'h0, lat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
